aq_dcache_tag_ctrl: RTL and testbench
=====================================

AQ_DCACHE_TAG_CTRL -- requirements
Module: aq_dcache_tag_ctrl

Interface
REQ-001 SHALL use reset as decided: one clock; reset is synchronous and active-high.
REQ-002 SHALL have these ports:
- forever_cpuclk  in  1  clock
- lsu_rst  in  1  synchronous active-high reset
- ld_req_vld  in  1  lookup request
- ld_req_idx  in  12  lookup address; set = [11:6]
- ld_req_tag  in  28  lookup tag
- ld_req_grnt  out  1  lookup accepted this cycle
- ld_rsp_vld  out  1  lookup result valid
- ld_rsp_hit  out  1  any way hit
- ld_rsp_hit_way  out  4  one-hot hit vector
- ld_rsp_multi_hit  out  1  more than one way hit (error)
- rf_req_vld  in  1  refill/line-update write request
- rf_req_idx  in  12  refill address; set = [11:6]
- rf_req_way  in  4  target ways
- rf_req_tag  in  28  tag to write
- rf_req_valid  in  1  valid bit to write
- rf_req_grnt  out  1  refill accepted this cycle
- inv_all_req  in  1  invalidate-all pulse
- inv_all_busy  out  1  sweep in progress
- inv_all_done  out  1  one-cycle sweep-complete pulse
- tag_cen  out  1  array enable, active low
- tag_gwen  out  1  global write enable, active low
- tag_wen  out  120  per-bit write enable, active low
- tag_din  out  120  write data
- tag_idx  out  12  array index; set = [11:6]
- tag_way  out  4  bank select
- tag_clk_en  out  1  array clock-gate enable
REQ-003 SHALL use this array word format: way w occupies bits [30w+29:30w]; tag is [30w+27:30w]; valid is 30w+29; bit 30w+28 is unused, written 0 and ignored on read.
REQ-004 SHALL take array read data on input tag_dout [119:0].

Function
REQ-005 SHALL use FSM states IDLE, SWEEP and DONE.
REQ-006 SHALL, on inv_all_req in IDLE, enter SWEEP next cycle with the sweep counter at 0; the port SHALL still serve normal traffic in the request cycle.
REQ-007 SHALL, in SWEEP, write one set per cycle: set = counter, tag_way=4'hF, tag_gwen=0, tag_din=0, tag_wen low only on the four valid bits.
REQ-008 SHALL, after set 63, go SWEEP->DONE->IDLE, with inv_all_done=1 for exactly the DONE cycle.
REQ-009 SHALL hold inv_all_busy=1 in SWEEP and DONE.
REQ-010 SHALL ignore inv_all_req while busy.
REQ-011 SHALL, in SWEEP and DONE, hold ld_req_grnt and rf_req_grnt at 0.
REQ-012 SHALL use this priority in IDLE: refill over lookup.
- rf_req_grnt = rf_req_vld.
- ld_req_grnt = ld_req_vld & ~rf_req_vld.
- Grants are combinational; requesters hold requests until granted.
REQ-013 SHALL perform a granted refill as a write in the same cycle:
- tag_gwen=0; tag_way=rf_req_way; tag_idx=rf_req_idx.
- For each selected way: tag_din carries rf_req_tag and rf_req_valid; tag_wen low on the tag and valid bits.
- For all other ways: tag_wen is high.
REQ-014 SHALL treat a granted refill with rf_req_way=0 as a no-op: granted, tag_cen=1.
REQ-015 SHALL perform a granted lookup as a read: tag_gwen=1, tag_wen all 1, tag_way=4'hF, tag_idx=ld_req_idx; ld_req_tag is registered.
REQ-016 SHALL assert ld_rsp_vld exactly one cycle after ld_req_grnt, with the following computed from tag_dout and the registered tag:
- ld_rsp_hit_way[w] = valid_w & (tag_w == registered tag).
- ld_rsp_hit = OR of ld_rsp_hit_way.
- ld_rsp_multi_hit = more than one way hit.
REQ-017 SHALL make a lookup granted the cycle after a refill to the same set observe the refilled data.
REQ-018 SHALL drive tag_clk_en = ~tag_cen in every cycle.
REQ-019 SHALL, when idle, drive tag_cen=1, tag_gwen=1, tag_wen all 1, tag_din=0, tag_way=0, tag_idx=0.

Reset
REQ-020 SHALL, while lsu_rst=1, force:
- state IDLE, counter 0;
- all grants, ld_rsp_*, inv_all_busy and inv_all_done to 0;
- the array port to its idle values from REQ-019.
REQ-021 SHALL, on reset during SWEEP, abandon the sweep with no inv_all_done pulse; a new inv_all_req SHALL be required to sweep.
REQ-022 SHALL, on reset in the cycle after a lookup grant, suppress ld_rsp_vld.

Structure
REQ-023 SHALL place the following in the shared LSU package:
- constants: tag width 28, index width 6, way count 4, way stride 30, valid offset 29;
- the FSM state enum.
REQ-024 SHALL implement the per-way compare as sub-module aq_dcache_tag_cmp, instanced four times.

Verification
REQ-025 SHALL pass these directed scenarios:
- Sweep: inv_all_req at cycle 0 -> 64 writes, tag_idx[11:6]=0..63 on cycles 1..64; inv_all_done at cycle 65; busy over cycles 1..65; no grants throughout.
- Refill then hit: refill idx=0x0C0, way=4'b0100, tag=0xABCDEF1, valid=1; next cycle lookup same idx/tag -> ld_rsp_vld one cycle later, hit_way=4'b0100, hit=1.
- Miss on invalid line: after the sweep, lookup any idx/tag -> hit=0, hit_way=0.
- Conflict: rf_req_vld and ld_req_vld in the same cycle -> rf_req_grnt=1, ld_req_grnt=0; lookup granted the next cycle.
- Multi-hit: the same tag written to ways 0 and 3 of one set, then looked up -> hit_way=4'b1001, multi_hit=1.
- Reset mid-sweep: lsu_rst at sweep set 20 -> busy=0 next cycle, no done pulse, tag_cen=1.

Source files
------------

// File: rtl/aq_dcache_tag_ctrl_pkg.sv
// Shared LSU definitions for the D-cache tag array controller:
// array geometry constants and the invalidate-all sweep FSM states.
package aq_dcache_tag_ctrl_pkg;

  localparam int unsigned TAG_W      = 28;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned WAY_N      = 4;
  localparam int unsigned WAY_STRIDE = 30;
  localparam int unsigned VLD_OFS    = 29;
  localparam int unsigned ARR_W      = WAY_N * WAY_STRIDE;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } tag_state_e;

endpackage

// File: rtl/aq_dcache_tag_cmp.sv
// Single-way tag compare: a way hits when its valid bit is set and its
// stored tag equals the registered lookup tag.
module aq_dcache_tag_cmp
  import aq_dcache_tag_ctrl_pkg::*;
(
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] ref_tag_i,
  output logic             hit_o
);

  assign hit_o = vld_i & (tag_i == ref_tag_i);

endmodule

// File: rtl/aq_dcache_tag_ctrl.sv
// D-cache tag array port controller: arbitrates refill writes over lookups,
// returns lookup hit results one cycle later, and runs an invalidate-all sweep.
module aq_dcache_tag_ctrl
  import aq_dcache_tag_ctrl_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               lsu_rst,
  input  logic               ld_req_vld,
  input  logic [11:0]        ld_req_idx,
  input  logic [TAG_W-1:0]   ld_req_tag,
  output logic               ld_req_grnt,
  output logic               ld_rsp_vld,
  output logic               ld_rsp_hit,
  output logic [WAY_N-1:0]   ld_rsp_hit_way,
  output logic               ld_rsp_multi_hit,
  input  logic               rf_req_vld,
  input  logic [11:0]        rf_req_idx,
  input  logic [WAY_N-1:0]   rf_req_way,
  input  logic [TAG_W-1:0]   rf_req_tag,
  input  logic               rf_req_valid,
  output logic               rf_req_grnt,
  input  logic               inv_all_req,
  output logic               inv_all_busy,
  output logic               inv_all_done,
  output logic               tag_cen,
  output logic               tag_gwen,
  output logic [ARR_W-1:0]   tag_wen,
  output logic [ARR_W-1:0]   tag_din,
  output logic [11:0]        tag_idx,
  output logic [WAY_N-1:0]   tag_way,
  output logic               tag_clk_en,
  input  logic [ARR_W-1:0]   tag_dout
);

  tag_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ld_pend_q;
  logic [TAG_W-1:0] ld_tag_q;
  logic [WAY_N-1:0] hit_raw;
  logic             unused_rsvd;

  // Reset overrides every output combinationally, so the array port is quiet
  // in the reset cycle itself rather than one cycle later.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_req_grnt  = 1'b0;
    rf_req_grnt  = 1'b0;
    inv_all_busy = 1'b0;
    inv_all_done = 1'b0;
    tag_cen      = 1'b1;
    tag_gwen     = 1'b1;
    tag_wen      = '1;
    tag_din      = '0;
    tag_way      = '0;
    tag_idx      = '0;
    if (!lsu_rst) begin
      unique case (state_q)
        IDLE: begin
          rf_req_grnt = rf_req_vld;
          ld_req_grnt = ld_req_vld & ~rf_req_vld;
          if (rf_req_vld) begin
            if (|rf_req_way) begin
              tag_cen  = 1'b0;
              tag_gwen = 1'b0;
              tag_way  = rf_req_way;
              tag_idx  = rf_req_idx;
              for (int unsigned w = 0; w < WAY_N; w++) begin
                if (rf_req_way[w]) begin
                  tag_din[w*WAY_STRIDE +: TAG_W]  = rf_req_tag;
                  tag_din[w*WAY_STRIDE + VLD_OFS] = rf_req_valid;
                  tag_wen[w*WAY_STRIDE +: TAG_W]  = '0;
                  tag_wen[w*WAY_STRIDE + VLD_OFS] = 1'b0;
                end
              end
            end
          end else if (ld_req_vld) begin
            tag_cen = 1'b0;
            tag_way = '1;
            tag_idx = ld_req_idx;
          end
          if (inv_all_req) begin
            state_d = SWEEP;
            cnt_d   = '0;
          end
        end
        SWEEP: begin
          inv_all_busy = 1'b1;
          tag_cen      = 1'b0;
          tag_gwen     = 1'b0;
          tag_way      = '1;
          tag_idx      = {cnt_q, 6'b0};
          for (int unsigned w = 0; w < WAY_N; w++) begin
            tag_wen[w*WAY_STRIDE + VLD_OFS] = 1'b0;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = DONE;
          end
        end
        DONE: begin
          inv_all_busy = 1'b1;
          inv_all_done = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tag_clk_en = ~tag_cen;

  always_ff @(posedge forever_cpuclk) begin
    if (lsu_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_pend_q <= 1'b0;
      ld_tag_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_pend_q <= ld_req_grnt;
      if (ld_req_grnt) begin
        ld_tag_q <= ld_req_tag;
      end
    end
  end

  for (genvar w = 0; w < WAY_N; w++) begin : g_cmp
    aq_dcache_tag_cmp u_cmp (
      .vld_i     (tag_dout[w*WAY_STRIDE + VLD_OFS]),
      .tag_i     (tag_dout[w*WAY_STRIDE +: TAG_W]),
      .ref_tag_i (ld_tag_q),
      .hit_o     (hit_raw[w])
    );
  end

  assign unused_rsvd = ^{tag_dout[118], tag_dout[88], tag_dout[58], tag_dout[28]};

  assign ld_rsp_vld       = ld_pend_q & ~lsu_rst;
  assign ld_rsp_hit_way   = ld_rsp_vld ? hit_raw : '0;
  assign ld_rsp_hit       = |ld_rsp_hit_way;
  assign ld_rsp_multi_hit = |(ld_rsp_hit_way & (ld_rsp_hit_way - 1'b1));

endmodule

// File: tb/tb_aq_dcache_tag_ctrl.sv
// Bench for aq_dcache_tag_ctrl: SRAM model, per-cycle behavioural reference
// (shadow cache contents + sweep position), directed scenarios and random traffic.
module tb_aq_dcache_tag_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, ld_vld, rf_vld, rf_valid, inv_req;
  logic [11:0]  ld_idx, rf_idx;
  logic [27:0]  ld_tag, rf_tag;
  logic [3:0]   rf_way;
  logic         ld_req_grnt, ld_rsp_vld, ld_rsp_hit, ld_rsp_multi_hit, rf_req_grnt;
  logic [3:0]   ld_rsp_hit_way, tag_way;
  logic         inv_all_busy, inv_all_done, tag_cen, tag_gwen, tag_clk_en;
  logic [119:0] tag_wen, tag_din, tag_dout;
  logic [11:0]  tag_idx;

  aq_dcache_tag_ctrl dut (
    .forever_cpuclk   (clk),
    .lsu_rst          (rst),
    .ld_req_vld       (ld_vld),
    .ld_req_idx       (ld_idx),
    .ld_req_tag       (ld_tag),
    .ld_req_grnt      (ld_req_grnt),
    .ld_rsp_vld       (ld_rsp_vld),
    .ld_rsp_hit       (ld_rsp_hit),
    .ld_rsp_hit_way   (ld_rsp_hit_way),
    .ld_rsp_multi_hit (ld_rsp_multi_hit),
    .rf_req_vld       (rf_vld),
    .rf_req_idx       (rf_idx),
    .rf_req_way       (rf_way),
    .rf_req_tag       (rf_tag),
    .rf_req_valid     (rf_valid),
    .rf_req_grnt      (rf_req_grnt),
    .inv_all_req      (inv_req),
    .inv_all_busy     (inv_all_busy),
    .inv_all_done     (inv_all_done),
    .tag_cen          (tag_cen),
    .tag_gwen         (tag_gwen),
    .tag_wen          (tag_wen),
    .tag_din          (tag_din),
    .tag_idx          (tag_idx),
    .tag_way          (tag_way),
    .tag_clk_en       (tag_clk_en),
    .tag_dout         (tag_dout)
  );

  // Single-port synchronous tag SRAM with per-bit write enables and bank selects.
  logic [119:0] mem [64];
  logic [119:0] wr_word;
  always @(posedge clk) begin
    if (!tag_cen) begin
      if (!tag_gwen) begin
        wr_word = mem[tag_idx[11:6]];
        for (int b = 0; b < 120; b++)
          if (!tag_wen[b] && tag_way[b/30]) wr_word[b] = tag_din[b];
        mem[tag_idx[11:6]] <= wr_word;
      end else begin
        tag_dout <= mem[tag_idx[11:6]];
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  function void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: what the cache holds, where a sweep is, and the pending lookup result.
  bit          sv [64][4];
  logic [27:0] st [64][4];
  int          sweep_pos = -1;   // -1 idle, 0..63 set being cleared, 64 completion cycle
  int          nxt_pos;
  bit          pend = 1'b0;
  logic [3:0]  exp_hw = '0, new_hw;
  bit          chk_en = 1'b0;

  bit           e_rfg, e_ldg, e_busy, e_done, e_vld, e_cen, e_gwen, noop;
  logic [119:0] e_wen, e_din;
  logic [3:0]   e_way;
  logic [11:0]  e_idx;
  int           din_mode, nhits;

  always @(negedge clk) begin
    if (chk_en) begin
      e_rfg = 0; e_ldg = 0; e_busy = 0; e_done = 0; e_vld = 0;
      e_cen = 1; e_gwen = 1; e_wen = '1; e_din = '0; e_way = '0; e_idx = '0;
      noop = 0; din_mode = 0; new_hw = '0; nxt_pos = -1;
      if (!rst) begin
        e_vld = pend;
        if (sweep_pos >= 0 && sweep_pos < 64) begin
          e_busy = 1; e_cen = 0; e_gwen = 0; e_way = 4'hF;
          e_idx = {6'(sweep_pos), 6'b0};
          for (int w = 0; w < 4; w++) begin
            e_wen[30*w+29] = 1'b0;
            sv[sweep_pos][w] = 1'b0;
          end
          nxt_pos = sweep_pos + 1;
        end else if (sweep_pos == 64) begin
          e_busy = 1; e_done = 1;
        end else begin
          e_rfg = rf_vld;
          e_ldg = ld_vld && !rf_vld;
          if (rf_vld) begin
            if (rf_way == 4'b0) noop = 1;
            else begin
              e_cen = 0; e_gwen = 0; e_way = rf_way; e_idx = rf_idx; din_mode = 1;
              for (int w = 0; w < 4; w++) if (rf_way[w]) begin
                e_wen[30*w +: 28] = '0;
                e_wen[30*w+29]    = 1'b0;
                e_din[30*w +: 28] = rf_tag;
                e_din[30*w+29]    = rf_valid;
                sv[rf_idx[11:6]][w] = rf_valid;
                st[rf_idx[11:6]][w] = rf_tag;
              end
            end
          end else if (ld_vld) begin
            e_cen = 0; e_way = 4'hF; e_idx = ld_idx; din_mode = 2;
            for (int w = 0; w < 4; w++)
              new_hw[w] = sv[ld_idx[11:6]][w] && (st[ld_idx[11:6]][w] == ld_tag);
          end
          if (inv_req) nxt_pos = 0;
        end
      end
      chk("rf_grnt", rf_req_grnt, e_rfg);
      chk("ld_grnt", ld_req_grnt, e_ldg);
      chk("busy", inv_all_busy, e_busy);
      chk("done", inv_all_done, e_done);
      chk("rsp_vld", ld_rsp_vld, e_vld);
      if (rst || e_vld) begin
        nhits = 0;
        for (int w = 0; w < 4; w++) if (e_vld && exp_hw[w]) nhits++;
        chk("hit_way", ld_rsp_hit_way, e_vld ? exp_hw : 4'b0);
        chk("hit", ld_rsp_hit, nhits > 0);
        chk("multi_hit", ld_rsp_multi_hit, nhits > 1);
      end
      chk("cen", tag_cen, e_cen);
      chk("clk_en", tag_clk_en, !e_cen);
      if (!noop) begin
        chk("gwen", tag_gwen, e_gwen);
        chk("wen", tag_wen, e_wen);
        chk("way", tag_way, e_way);
        chk("idx", tag_idx, e_idx);
        if (din_mode == 0) chk("din", tag_din, e_din);
        else if (din_mode == 1) chk("din_wr", tag_din & ~tag_wen, e_din & ~e_wen);
      end
      sweep_pos = nxt_pos;
      pend = e_ldg;
      if (e_ldg) exp_hw = new_hw;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ld_vld = 0; rf_vld = 0; inv_req = 0; rf_way = '0; rf_valid = 0;
  endtask

  initial begin
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        sv[s][w] = 1'($urandom);
        st[s][w] = 28'($urandom_range(0, 3));
        mem[s][30*w +: 28] = st[s][w];
        mem[s][30*w+28]    = 1'($urandom);
        mem[s][30*w+29]    = sv[s][w];
      end
    rst = 1; quiet(); ld_idx = '0; ld_tag = '0; rf_idx = '0; rf_tag = '0;
    chk_en = 1;
    step(); step(); step();
    @(negedge clk);
    chk("rst_cen", tag_cen, 1);
    chk("rst_busy", inv_all_busy, 0);
    step();
    rst = 0;

    // Full sweep with a lookup held pending throughout.
    inv_req = 1;
    step();
    inv_req = 0; ld_vld = 1; ld_idx = 12'h3C5; ld_tag = 28'h1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("sweep_idx", tag_idx[11:6], i);
      chk("sweep_busy", inv_all_busy, 1);
      chk("sweep_ldg", ld_req_grnt, 0);
      step();
    end
    ld_vld = 0;
    @(negedge clk);
    chk("sweep_done", inv_all_done, 1);
    chk("sweep_done_busy", inv_all_busy, 1);
    step();
    @(negedge clk);
    chk("post_done", inv_all_done, 0);
    chk("post_busy", inv_all_busy, 0);

    // Refill then hit.
    step();
    rf_vld = 1; rf_idx = 12'h0C0; rf_way = 4'b0100; rf_tag = 28'hABCDEF1; rf_valid = 1;
    @(negedge clk);
    chk("rf_grnt_lit", rf_req_grnt, 1);
    step();
    quiet(); ld_vld = 1; ld_idx = 12'h0C0; ld_tag = 28'hABCDEF1;
    @(negedge clk);
    chk("ld_grnt_lit", ld_req_grnt, 1);
    step();
    quiet();
    @(negedge clk);
    chk("rh_vld", ld_rsp_vld, 1);
    chk("rh_way", ld_rsp_hit_way, 4'b0100);
    chk("rh_hit", ld_rsp_hit, 1);

    // Miss on a swept (invalid) set.
    step();
    ld_vld = 1; ld_idx = 12'h100; ld_tag = 28'h1234567;
    step();
    quiet();
    @(negedge clk);
    chk("miss_hit", ld_rsp_hit, 0);
    chk("miss_way", ld_rsp_hit_way, 4'b0);

    // Refill/lookup conflict.
    step();
    rf_vld = 1; rf_idx = 12'h040; rf_way = 4'b0001; rf_tag = 28'h55; rf_valid = 1;
    ld_vld = 1; ld_idx = 12'h040; ld_tag = 28'h55;
    @(negedge clk);
    chk("cf_rfg", rf_req_grnt, 1);
    chk("cf_ldg", ld_req_grnt, 0);
    step();
    rf_vld = 0;
    @(negedge clk);
    chk("cf_ldg2", ld_req_grnt, 1);
    step();
    quiet();
    @(negedge clk);
    chk("cf_way", ld_rsp_hit_way, 4'b0001);

    // Multi-hit.
    step();
    rf_vld = 1; rf_idx = 12'h280; rf_way = 4'b1001; rf_tag = 28'h7654321; rf_valid = 1;
    step();
    quiet(); ld_vld = 1; ld_idx = 12'h280; ld_tag = 28'h7654321;
    step();
    quiet();
    @(negedge clk);
    chk("mh_way", ld_rsp_hit_way, 4'b1001);
    chk("mh_multi", ld_rsp_multi_hit, 1);

    // Reset in the cycle that clears set 20.
    step();
    inv_req = 1;
    step();
    inv_req = 0;
    repeat (19) step();
    @(negedge clk);
    chk("rs_idx19", tag_idx[11:6], 19);
    step();
    rst = 1;
    @(negedge clk);
    chk("rs_cen", tag_cen, 1);
    chk("rs_busy", inv_all_busy, 0);
    step();
    rst = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      chk("rs_nodone", inv_all_done, 0);
      chk("rs_idle_busy", inv_all_busy, 0);
      step();
    end

    // Random traffic over four sets and a small tag pool.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      inv_req  = ($urandom_range(0, 149) == 0);
      rf_vld   = ($urandom_range(0, 3) == 0);
      rf_idx   = {4'b0, 2'($urandom), 6'($urandom)};
      rf_way   = 4'($urandom);
      rf_tag   = 28'($urandom_range(0, 3));
      rf_valid = ($urandom_range(0, 3) != 0);
      ld_vld   = ($urandom_range(0, 1) == 0);
      ld_idx   = {4'b0, 2'($urandom), 6'($urandom)};
      ld_tag   = 28'($urandom_range(0, 3));
      step();
    end
    rst = 0; quiet();
    repeat (80) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
